mine_field_generator: RTL and testbench



---
 rtl/mine_gen_pkg.sv | 42 ++++
 rtl/mine_gen_lfsr.sv | 26 ++
 rtl/mine_field_generator.sv | 211 +++++++++++++++++++++
 tb/tb_mine_field_generator.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mine_gen_pkg.sv
// Shared types and helpers for the mine field generator: FSM states,
// Fibonacci LFSR tap masks and the safe-zone tile count.
package mine_gen_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      PLACE  = 2'd2,
      FINISH = 2'd3
   } state_e;

   // Tap masks, bit (n-1) set for tap position n
   localparam logic [31:0] TAPS_16 = 32'h0000_B400;
   localparam logic [31:0] TAPS_24 = 32'h00E1_0000;
   localparam logic [31:0] TAPS_32 = 32'h8020_0003;

   function automatic logic [31:0] lfsr_next(input int unsigned width, input logic [31:0] value);
      logic [31:0] taps;
      logic [31:0] mask;
      logic        fb;
      case (width)
         32'd24:  taps = TAPS_24;
         32'd32:  taps = TAPS_32;
         default: taps = TAPS_16;
      endcase
      mask = (width >= 32'd32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      fb   = ^(value & taps);
      return {value[30:0], fb} & mask;
   endfunction

   function automatic int unsigned safe_count(input int unsigned r, input int unsigned c,
                                              input int unsigned radius,
                                              input int unsigned rows, input int unsigned cols);
      int unsigned r_lo, r_hi, c_lo, c_hi;
      r_lo = (r > radius) ? r - radius : 32'd0;
      r_hi = (r + radius > rows - 32'd1) ? rows - 32'd1 : r + radius;
      c_lo = (c > radius) ? c - radius : 32'd0;
      c_hi = (c + radius > cols - 32'd1) ? cols - 32'd1 : c + radius;
      return (r_hi - r_lo + 32'd1) * (c_hi - c_lo + 32'd1);
   endfunction

endpackage

// File: rtl/mine_gen_lfsr.sv
// Free-running Fibonacci LFSR; advances every cycle so request timing adds entropy.
module mine_gen_lfsr
   import mine_gen_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter logic [31:0] SEED  = 32'h0000ACE1
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] value
);

   logic [WIDTH-1:0] lfsr_r;

   // Shift register, reloaded with the seed on reset
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_r <= SEED[WIDTH-1:0];
      end else begin
         lfsr_r <= WIDTH'(lfsr_next(WIDTH, 32'(lfsr_r)));
      end
   end

   assign value = lfsr_r;

endmodule

// File: rtl/mine_field_generator.sv
// Places num_mines mines on a ROWS x COLS board by LFSR rejection sampling, keeping a
// safe square around the root tile. Define MINE_GEN_PROBE_FALLBACK_EN for linear-probe fallback.
module mine_field_generator
   import mine_gen_pkg::*;
#(
   parameter int unsigned ROWS        = 8,
   parameter int unsigned COLS        = 8,
   parameter int unsigned TILES       = ROWS * COLS,
   parameter int unsigned ROW_W       = $clog2(ROWS),
   parameter int unsigned COL_W       = $clog2(COLS),
   parameter int unsigned CNT_W       = $clog2(TILES + 1),
   parameter int unsigned SAFE_RADIUS = 1,
   parameter int unsigned LFSR_W      = 16,
   parameter logic [31:0] SEED        = 32'h0000ACE1,
   parameter int unsigned MAX_REJECT  = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [ROW_W-1:0] root_row,
   input  logic [COL_W-1:0] root_col,
   input  logic [CNT_W-1:0] num_mines,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [TILES-1:0] mine_map,
   output logic [CNT_W-1:0] placed_count
);

   localparam int unsigned IDX_W = ROW_W + COL_W + 1;

   state_e           state_r;
   logic [ROW_W-1:0] root_row_r;
   logic [COL_W-1:0] root_col_r;
   logic [CNT_W-1:0] num_mines_r;
   logic             busy_r, done_r, error_r;
   logic [TILES-1:0] mine_map_r;
   logic [CNT_W-1:0] placed_count_r;

   logic [LFSR_W-1:0] lfsr_s;
   logic              unused_lfsr_s;
   logic [ROW_W-1:0]  cand_row_s, row_diff_s;
   logic [COL_W-1:0]  cand_col_s, col_diff_s;
   logic [IDX_W-1:0]  idx_s;
   logic [TILES-1:0]  bit_s;
   logic              in_range_s, in_safe_s, occupied_s, accept_s;
   logic              root_bad_s, over_cap_s;
   int unsigned       safe_cnt_s;

   mine_gen_lfsr #(.WIDTH(LFSR_W), .SEED(SEED)) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .value (lfsr_s)
   );

   assign unused_lfsr_s = ^lfsr_s;
   assign safe_cnt_s    = safe_count(32'(root_row_r), 32'(root_col_r), SAFE_RADIUS, ROWS, COLS);
   assign root_bad_s    = (32'(root_row_r) >= ROWS) || (32'(root_col_r) >= COLS);
   assign over_cap_s    = 32'(num_mines_r) > (TILES - safe_cnt_s);

`ifdef MINE_GEN_PROBE_FALLBACK_EN
   localparam int unsigned REJ_W = $clog2(MAX_REJECT + 1);

   logic [REJ_W-1:0] reject_cnt_r;
   logic [ROW_W-1:0] last_row_r, probe_row_s;
   logic [COL_W-1:0] last_col_r, probe_col_s;
   logic             probe_s;

   assign probe_s = 32'(reject_cnt_r) >= MAX_REJECT;

   // Next tile in raster order after the last in-range candidate
   always_comb begin
      if (32'(last_col_r) >= COLS - 32'd1) begin
         probe_col_s = {COL_W{1'b0}};
         probe_row_s = (32'(last_row_r) >= ROWS - 32'd1) ? {ROW_W{1'b0}} : last_row_r + ROW_W'(1'b1);
      end else begin
         probe_col_s = last_col_r + COL_W'(1'b1);
         probe_row_s = last_row_r;
      end
   end

   // Consecutive-reject counter and last in-range candidate
   always_ff @(posedge clk) begin
      if (rst || state_r == CHECK) begin
         reject_cnt_r <= {REJ_W{1'b0}};
         last_row_r   <= {ROW_W{1'b0}};
         last_col_r   <= {COL_W{1'b0}};
      end else if (state_r == PLACE) begin
         if (accept_s) begin
            reject_cnt_r <= {REJ_W{1'b0}};
         end else if (!probe_s) begin
            reject_cnt_r <= reject_cnt_r + REJ_W'(1'b1);
         end else begin
            reject_cnt_r <= reject_cnt_r;
         end
         if (in_range_s) begin
            last_row_r <= cand_row_s;
            last_col_r <= cand_col_s;
         end else begin
            last_row_r <= last_row_r;
            last_col_r <= last_col_r;
         end
      end else begin
         reject_cnt_r <= reject_cnt_r;
      end
   end
`else
   localparam int unsigned unused_max_reject = MAX_REJECT;
`endif

   // Candidate selection and accept/reject decision
   always_comb begin
      cand_row_s = lfsr_s[ROW_W-1:0];
      cand_col_s = lfsr_s[ROW_W+COL_W-1:ROW_W];
`ifdef MINE_GEN_PROBE_FALLBACK_EN
      if (probe_s) begin
         cand_row_s = probe_row_s;
         cand_col_s = probe_col_s;
      end else begin
         cand_row_s = lfsr_s[ROW_W-1:0];
         cand_col_s = lfsr_s[ROW_W+COL_W-1:ROW_W];
      end
`endif
      in_range_s = (32'(cand_row_s) < ROWS) && (32'(cand_col_s) < COLS);
      row_diff_s = (cand_row_s >= root_row_r) ? cand_row_s - root_row_r : root_row_r - cand_row_s;
      col_diff_s = (cand_col_s >= root_col_r) ? cand_col_s - root_col_r : root_col_r - cand_col_s;
      in_safe_s  = (32'(row_diff_s) <= SAFE_RADIUS) && (32'(col_diff_s) <= SAFE_RADIUS);
      idx_s      = IDX_W'(cand_row_s) * IDX_W'(COLS) + IDX_W'(cand_col_s);
      bit_s      = TILES'(1'b1) << idx_s;
      occupied_s = |(mine_map_r & bit_s);
      accept_s   = (state_r == PLACE) && in_range_s && !in_safe_s && !occupied_s;
   end

   // Control FSM and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= IDLE;
         root_row_r     <= {ROW_W{1'b0}};
         root_col_r     <= {COL_W{1'b0}};
         num_mines_r    <= {CNT_W{1'b0}};
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
         error_r        <= 1'b0;
         mine_map_r     <= {TILES{1'b0}};
         placed_count_r <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  root_row_r  <= root_row;
                  root_col_r  <= root_col;
                  num_mines_r <= num_mines;
                  error_r     <= 1'b0;
                  busy_r      <= 1'b1;
                  state_r     <= CHECK;
               end else begin
                  state_r <= IDLE;
               end
            end
            CHECK: begin
               mine_map_r     <= {TILES{1'b0}};
               placed_count_r <= {CNT_W{1'b0}};
               if (root_bad_s || over_cap_s) begin
                  error_r <= 1'b1;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= FINISH;
               end else if (num_mines_r == {CNT_W{1'b0}}) begin
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= FINISH;
               end else begin
                  state_r <= PLACE;
               end
            end
            PLACE: begin
               if (accept_s) begin
                  mine_map_r     <= mine_map_r | bit_s;
                  placed_count_r <= placed_count_r + CNT_W'(1'b1);
               end else begin
                  mine_map_r <= mine_map_r;
               end
               if (placed_count_r + CNT_W'(accept_s) == num_mines_r) begin
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= FINISH;
               end else begin
                  state_r <= PLACE;
               end
            end
            FINISH: begin
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign busy         = busy_r;
   assign done         = done_r;
   assign error        = error_r;
   assign mine_map     = mine_map_r;
   assign placed_count = placed_count_r;

endmodule

// File: tb/tb_mine_field_generator.sv
// Bench for mine_field_generator: an 8x8 and a 16x30 instance driven by directed and
// random requests, checked against a tile-level placement model fed by a reference LFSR.
module tb_mine_field_generator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_a, start_a, busy_a, done_a, error_a;
   logic [2:0]   rr_a, rc_a;
   logic [6:0]   nm_a, pc_a;
   logic [63:0]  map_a;
   logic         rst_b, start_b, busy_b, done_b, error_b;
   logic [3:0]   rr_b;
   logic [4:0]   rc_b;
   logic [8:0]   nm_b, pc_b;
   logic [479:0] map_b;

   logic [31:0]  m_lfsr_a, m_lfsr_b;
   int           passed = 0;
   int           total  = 0;

   mine_field_generator dut_a (
      .clk(clk), .rst(rst_a), .start(start_a), .root_row(rr_a), .root_col(rc_a),
      .num_mines(nm_a), .busy(busy_a), .done(done_a), .error(error_a),
      .mine_map(map_a), .placed_count(pc_a)
   );

   mine_field_generator #(.ROWS(16), .COLS(30), .LFSR_W(24)) dut_b (
      .clk(clk), .rst(rst_b), .start(start_b), .root_row(rr_b), .root_col(rc_b),
      .num_mines(nm_b), .busy(busy_b), .done(done_b), .error(error_b),
      .mine_map(map_b), .placed_count(pc_b)
   );

   // Fibonacci step from the listed tap positions
   function automatic logic [31:0] model_step(input int w, input logic [31:0] v);
      int   t [4];
      logic fb;
      if (w == 24) t = '{24, 23, 22, 17};
      else         t = '{16, 14, 13, 11};
      fb = 1'b0;
      foreach (t[i]) fb = fb ^ v[t[i]-1];
      return ((v << 1) | 32'(fb)) & ((32'd1 << w) - 32'd1);
   endfunction

   function automatic bit near(input int a, input int b, input int ra, input int rb);
      return (a - ra <= 1) && (ra - a <= 1) && (b - rb <= 1) && (rb - b <= 1);
   endfunction

   always @(posedge clk) begin
      m_lfsr_a <= rst_a ? 32'h0000ACE1 : model_step(16, m_lfsr_a);
      m_lfsr_b <= rst_b ? 32'h0000ACE1 : model_step(24, m_lfsr_b);
   end

   task automatic chk(input string tag, input logic [479:0] obs, input logic [479:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic run_gen(input bit big, input int r, input int c, input int n, input bit poke);
      int           rows, cols, rw, cw, safe, cnt, cr, cc, dones;
      bit           illegal, ok;
      logic [479:0] exp_map;
      logic [31:0]  lv;
      rows = big ? 16 : 8;
      cols = big ? 30 : 8;
      rw   = big ? 4 : 3;
      cw   = big ? 5 : 3;
      @(negedge clk);
      if (big) begin
         start_b = 1'b1; rr_b = 4'(r); rc_b = 5'(c); nm_b = 9'(n);
      end else begin
         start_a = 1'b1; rr_a = 3'(r); rc_a = 3'(c); nm_a = 7'(n);
      end
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      chk("busy_after_start", big ? busy_b : busy_a, 1'b1);
      if (poke) begin
         if (big) start_b = 1'b1;
         else     start_a = 1'b1;
      end
      safe = 0;
      for (int t = 0; t < rows * cols; t++) if (near(t / cols, t % cols, r, c)) safe++;
      illegal = (r >= rows) || (c >= cols) || (n > rows * cols - safe);
      exp_map = '0;
      cnt     = 0;
      if (illegal || n == 0) begin
         @(negedge clk);
         start_a = 1'b0;
         start_b = 1'b0;
      end else begin
         ok = 1'b0;
         for (int k = 0; k < 20000 && !ok; k++) begin
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            lv = big ? m_lfsr_b : m_lfsr_a;
            cr = int'(lv & ((32'd1 << rw) - 32'd1));
            cc = int'((lv >> rw) & ((32'd1 << cw) - 32'd1));
            if (cr < rows && cc < cols && !near(cr, cc, r, c) && !exp_map[cr * cols + cc]) begin
               exp_map[cr * cols + cc] = 1'b1;
               cnt++;
            end
            if (cnt == n) ok = 1'b1;
         end
         chk("place_budget", ok, 1'b1);
         @(negedge clk);
      end
      chk("done_pulse",  big ? done_b  : done_a,  1'b1);
      chk("busy_final",  big ? busy_b  : busy_a,  1'b0);
      chk("error_flag",  big ? error_b : error_a, illegal);
      chk("mine_map",    big ? map_b   : {416'd0, map_a}, exp_map);
      chk("placed_count", big ? pc_b   : pc_a, (illegal || n == 0) ? 0 : n);
      dones = 1;
      repeat (4) begin
         @(negedge clk);
         if ((big ? done_b : done_a) === 1'b1) dones++;
      end
      chk("single_done", dones, 1);
   endtask

   initial begin
      logic [63:0] full;
      rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
      rr_a = 3'd0; rc_a = 3'd0; nm_a = 7'd0;
      rr_b = 4'd0; rc_b = 5'd0; nm_b = 9'd0;
      repeat (3) @(negedge clk);
      chk("rst_outputs_a", {busy_a, done_a, error_a, map_a, pc_a}, '0);
      chk("rst_outputs_b", {busy_b, done_b, error_b, map_b, pc_b}, '0);
      chk("rst_lfsr_a", dut_a.u_lfsr.lfsr_r, 16'hACE1);
      rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);
      chk("lfsr_first_a", dut_a.u_lfsr.lfsr_r, model_step(16, 32'h0000ACE1));
      chk("lfsr_first_b", dut_b.u_lfsr.lfsr_r, model_step(24, 32'h0000ACE1));

      run_gen(1'b0, 0, 0, 10, 1'b0);
      chk("corner_safe_clear", {map_a[9], map_a[8], map_a[1], map_a[0]}, 4'b0000);
      run_gen(1'b0, 3, 3, 56, 1'b0);
      run_gen(1'b0, 3, 3, 55, 1'b0);
      full = '0;
      for (int t = 0; t < 64; t++) full[t] = !near(t / 8, t % 8, 3, 3);
      chk("full_map", map_a, full);
      run_gen(1'b0, 5, 2, 0, 1'b1);
      repeat (4) run_gen(1'b0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(1, 50), 1'b0);

      run_gen(1'b1, 15, 29, 99, 1'b0);
      run_gen(1'b1, 2, 30, 1, 1'b0);

      @(negedge clk);
      start_b = 1'b1; rr_b = 4'd0; rc_b = 5'd0; nm_b = 9'd99;
      @(negedge clk);
      start_b = 1'b0;
      repeat (10) @(negedge clk);
      chk("busy_mid_place", busy_b, 1'b1);
      rst_b = 1'b1;
      @(negedge clk);
      chk("mid_rst_outputs", {busy_b, done_b, error_b, map_b, pc_b}, '0);
      rst_b = 1'b0;
      run_gen(1'b1, $urandom_range(0, 15), $urandom_range(0, 29), $urandom_range(1, 200), 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
